// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO control blocks.
//   - wr_state_e : write-side FSM state encoding (IDLE=0, FULL=1, PUSH=2),
//                  numbered the same way as the read-side FSM.
//   - FIFO_AW    : default address width.
//   - fifo_ptr_w : pointer width for a given address width (address + wrap bit).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_AW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_PUSH = 2'd2
    } wr_state_e;

    // Binary pointers carry one extra wrap bit beyond the address.
    function automatic int fifo_ptr_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_cmp.sv
// -----------------------------------------------------------------------------
// fifo_ptr_cmp
// Occupancy arithmetic for the write controller.
// Ports:
//   wr_ptr_i      in  AW+1  writer binary pointer (with wrap bit)
//   rd_ptr_i      in  AW+1  reader binary pointer (with wrap bit)
//   push_i        in  1     write strobe of the current cycle
//   occ_o         out AW+1  (wr_ptr - rd_ptr) mod 2**(AW+1)
//   occ_next_o    out AW+1  occ + push
//   almost_full_o out 1     occ >= AF_LVL
// -----------------------------------------------------------------------------
module fifo_ptr_cmp
    import fifo_pkg::*;
#(
    parameter int AW     = FIFO_AW,
    parameter int AF_LVL = 6
) (
    input  logic [AW:0] wr_ptr_i,
    input  logic [AW:0] rd_ptr_i,
    input  logic        push_i,
    output logic [AW:0] occ_o,
    output logic [AW:0] occ_next_o,
    output logic        almost_full_o
);

    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LVL);

    logic [AW:0] occ_s;

    // Modular subtraction: the wrap bit makes a full FIFO read as DEPTH, not 0.
    assign occ_s         = wr_ptr_i - rd_ptr_i;
    assign occ_next_o    = occ_s + {{AW{1'b0}}, push_i};
    assign almost_full_o = (occ_s >= AF_THR);
    assign occ_o         = occ_s;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of a FIFO: Moore FSM (IDLE / FULL / PUSH) that turns a
// level-sensitive producer request into one-cycle-delayed memory write strobes
// and maintains the writer's binary pointer.
// Ports:
//   clk         in  1     clock, rising edge
//   arst_n      in  1     asynchronous active-low reset
//   en          in  1     producer write request (level)
//   rd_ptr      in  AW+1  reader binary pointer
//   push        out 1     memory write strobe (state == PUSH)
//   address     out AW    memory write address (wr_ptr[AW-1:0])
//   wr_ptr      out AW+1  writer binary pointer
//   full        out 1     state == FULL
//   almost_full out 1     occupancy >= AF_LVL (combinational)
//   count       out AW+1  occupancy (combinational)
//   ovf         out 1     sticky overflow; exists only with FIFO_WR_OVF_EN
// Build option: define FIFO_WR_OVF_EN to add the ovf port and its register.
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int AW     = FIFO_AW,
    parameter int AF_LVL = 6
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          en,
    input  logic [AW:0]   rd_ptr,
    output logic          push,
    output logic [AW-1:0] address,
    output logic [AW:0]   wr_ptr,
    output logic          full,
    output logic          almost_full,
`ifdef FIFO_WR_OVF_EN
    output logic          ovf,
`endif
    output logic [AW:0]   count
);

    localparam int          PW      = fifo_ptr_w(AW);
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wr_state_e       state_q;
    wr_state_e       state_d;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [AW:0]     occ_s;
    logic [AW:0]     occ_next_s;
    logic            push_s;

    // Strobe is a pure state decode, so async reset removes it within the cycle.
    assign push_s = (state_q == ST_PUSH);

    fifo_ptr_cmp #(
        .AW     (AW),
        .AF_LVL (AF_LVL)
    ) u_ptr_cmp (
        .wr_ptr_i      (wr_ptr_q),
        .rd_ptr_i      (rd_ptr),
        .push_i        (push_s),
        .occ_o         (occ_s),
        .occ_next_o    (occ_next_s),
        .almost_full_o (almost_full)
    );

    // Next-state: FULL takes priority once the in-flight push would fill the FIFO.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE, ST_FULL, ST_PUSH: begin
                if (occ_next_s == DEPTH_V) begin
                    state_d = ST_FULL;
                end else if (en) begin
                    state_d = ST_PUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer advances only at the edge that closes a push cycle.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

`ifdef FIFO_WR_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Sticky: any request seen while FULL is a lost write.
    always_comb begin
        ovf_d = ovf_q | (en & (state_q == ST_FULL));
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign push    = push_s;
    assign full    = (state_q == ST_FULL);
    assign address = wr_ptr_q[AW-1:0];
    assign wr_ptr  = wr_ptr_q;
    assign count   = occ_s;

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3, meaning address width; FIFO depth DEPTH = 2**AW.
REQ-002 SHALL have parameter AF_LVL, default 6, meaning the almost_full occupancy threshold; legal range 1..DEPTH.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  meaning producer write request, level-sensitive.
REQ-006 SHALL have port rd_ptr  input  AW+1  meaning the reader's binary pointer, including the wrap bit.
REQ-007 SHALL have port push  output  1  meaning the memory write strobe for the current cycle.
REQ-008 SHALL have port address  output  AW  meaning the memory write address, equal to wr_ptr[AW-1:0].
REQ-009 SHALL have port wr_ptr  output  AW+1  meaning the writer's binary pointer, including the wrap bit.
REQ-010 SHALL have port full  output  1  meaning the state is FULL.
REQ-011 SHALL have port almost_full  output  1  meaning occ >= AF_LVL.
REQ-012 SHALL have port count  output  AW+1  meaning occupancy occ = (wr_ptr - rd_ptr) mod 2**(AW+1).
REQ-013 SHALL have port ovf  output  1  meaning sticky overflow, present only with FIFO_WR_OVF_EN.

Function
REQ-014 SHALL implement a Moore FSM with the states IDLE, FULL and PUSH.
REQ-015 SHALL compute occ_next = occ + push, with width AW+1.
REQ-016 SHALL set next state FULL when occ_next == DEPTH, else PUSH when en=1, else IDLE; this rule applies in every state, and an illegal encoding goes to IDLE.
REQ-017 SHALL drive push = (state==PUSH) and full = (state==FULL), both registered-state decodes.
REQ-018 SHALL give one-cycle latency: en sampled high at edge k with room available gives push=1 in cycle k..k+1.
REQ-019 SHALL increment wr_ptr by 1 at the rising edge ending each push cycle, and SHALL NOT change it otherwise.
REQ-020 SHALL wrap wr_ptr from 2**(AW+1)-1 to 0 while address wraps from DEPTH-1 to 0.
REQ-021 SHALL sustain back-to-back pushes, one per cycle, while en=1 and occ_next < DEPTH.
REQ-022 SHALL never exceed DEPTH entries; en while in FULL or entering FULL is ignored, with no push and no pointer change.
REQ-023 SHALL, in FULL, go to PUSH (en=1) or IDLE (en=0) on the first edge where rd_ptr advance makes occ < DEPTH.
REQ-024 SHALL derive count and almost_full combinationally from wr_ptr and the current rd_ptr.

Reset
REQ-025 SHALL, on arst_n low, immediately force state=IDLE, wr_ptr=0, push=0, full=0 and ovf=0; count and almost_full follow from rd_ptr.
REQ-026 SHALL, on reset assertion during a PUSH cycle, drop push within the same cycle and discard the pending pointer increment.
REQ-027 SHALL treat reset release as synchronous to clk externally; the first evaluation happens at the first edge with arst_n high.

Configuration
REQ-028 SHALL, with FIFO_WR_OVF_EN defined, set ovf to 1 at the edge where en=1 and state==FULL, and hold it until reset.
REQ-029 SHALL, without FIFO_WR_OVF_EN, omit the ovf port and its register, with all other behaviour identical.

Structure
REQ-030 SHALL place the state encodings (IDLE=0, FULL=1, PUSH=2, shared with the read-side FSM numbering style) and the pointer-width constant in package fifo_pkg.
REQ-031 SHALL instantiate one sub-module, fifo_ptr_cmp, which computes occ, occ_next and almost_full from wr_ptr, rd_ptr and push.

Verification
REQ-032 SHALL cover reset: AW=3, arst_n low mid-stream -> push=0, wr_ptr=0, full=0 and count=rd_ptr-derived immediately, with no clock needed.
REQ-033 SHALL cover fill: rd_ptr=0, en=1 for 10 cycles -> exactly 8 push cycles, address 0..7, then full=1, wr_ptr=8, count=8, with almost_full=1 from count=6 onward.
REQ-034 SHALL cover overflow: full=1, en=1 for 3 cycles -> push=0 and wr_ptr=8; ovf=1 with the macro; no ovf port without it.
REQ-035 SHALL cover drain release: from full, rd_ptr 0->1 with en=1 -> next cycle push=1 with address=0, then back to full with wr_ptr=9.
REQ-036 SHALL cover pointer wrap: cycle 16 writes against a tracking reader -> wr_ptr wraps 15->0, address 7->0, and count stays correct across the wrap.
REQ-037 SHALL cover en gaps: en pattern 1,0,1,1,0 with an empty FIFO -> push pattern delayed one cycle (0,1,0,1,1), wr_ptr=3 at the end.
